// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: master IDs, access-size encodings
// and the packed request bundle routed to the slave port.
package sram_arbiter_pkg;

    localparam logic MASTER_INST = 1'b0;
    localparam logic MASTER_DATA = 1'b1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sreq_t;

endpackage

// File: rtl/arb_id_fifo.sv
// Owner-ID FIFO: remembers which master issued each accepted slave request so
// responses can be routed back in acceptance order.
module arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_din,
    input  logic                     i_pop,
    output logic                     o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // Guard against overflow/underflow so the count stays within 0..DEPTH
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master (instruction/data) arbiter onto one pipelined SRAM-like slave.
// Data master has fixed priority; responses return in order via an owner-ID FIFO.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_req,
    input  logic                    inst_wr,
    input  logic [1:0]              inst_size,
    input  logic [31:0]             inst_addr,
    input  logic [31:0]             inst_wdata,
    output logic                    inst_addr_ok,
    output logic                    inst_data_ok,
    output logic [31:0]             inst_rdata,
    input  logic                    data_req,
    input  logic                    data_wr,
    input  logic [1:0]              data_size,
    input  logic [31:0]             data_addr,
    input  logic [31:0]             data_wdata,
    output logic                    data_addr_ok,
    output logic                    data_data_ok,
    output logic [31:0]             data_rdata,
    output logic                    s_req,
    output logic                    s_wr,
    output logic [1:0]              s_size,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    input  logic                    s_addr_ok,
    input  logic                    s_data_ok,
    input  logic [31:0]             s_rdata,
    output logic [$clog2(DEPTH):0]  outstanding,
    output logic                    err
);

    logic                   w_grant_data;
    logic                   w_grant_inst;
    logic                   w_grant_any;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_accept;
    logic                   w_pop;
    logic                   w_head;
    logic                   w_owner;
    logic [$clog2(DEPTH):0] w_count;
    sreq_t                  w_sel;
    logic                   r_err;

    assign w_grant_data = data_req;
    assign w_grant_inst = !data_req && inst_req;
    assign w_grant_any  = w_grant_data || w_grant_inst;

    always_comb begin
        w_sel = '0;
        if (w_grant_data)
            w_sel = {data_wr, data_size, data_addr, data_wdata};
        else if (w_grant_inst)
            w_sel = {inst_wr, inst_size, inst_addr, inst_wdata};
    end

    // Full blocks new requests even when a response pops this cycle
    assign s_req = !rst && w_grant_any && !w_full;
    assign {s_wr, s_size, s_addr, s_wdata} = rst ? '0 : w_sel;

    assign w_accept     = s_req && s_addr_ok;
    assign data_addr_ok = w_accept && w_grant_data;
    assign inst_addr_ok = w_accept && w_grant_inst;
    assign w_owner      = w_grant_data ? MASTER_DATA : MASTER_INST;

    assign w_pop        = !rst && s_data_ok && !w_empty;
    assign data_data_ok = w_pop && (w_head == MASTER_DATA);
    assign inst_data_ok = w_pop && (w_head == MASTER_INST);
    assign data_rdata   = data_data_ok ? s_rdata : '0;
    assign inst_rdata   = inst_data_ok ? s_rdata : '0;

    assign outstanding = rst ? '0 : w_count;
    assign err         = r_err && !rst;

    // A response with nothing outstanding is a slave protocol violation
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (s_data_ok && w_empty)
            r_err <= 1'b1;
    end

    arb_id_fifo #(
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_din   (w_owner),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: DEPTH, 4, maximum outstanding slave transactions (power of two, >=2).
REQ-002 clk  in  1  single clock, all logic on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 inst_req/inst_wr  in  1/1  instruction-master request, write flag.
REQ-005 inst_size/inst_addr/inst_wdata  in  2/32/32  size (00 byte, 01 half, 10 word), address, write data.
REQ-006 inst_addr_ok/inst_data_ok  out  1/1  request accepted; response valid.
REQ-007 inst_rdata  out  32  read data to instruction master.
REQ-008 data_req/data_wr/data_size/data_addr/data_wdata  in  1/1/2/32/32  data-master request, same semantics as the inst_* inputs.
REQ-009 data_addr_ok/data_data_ok/data_rdata  out  1/1/32  data-master handshake and read data.
REQ-010 s_req/s_wr/s_size/s_addr/s_wdata  out  1/1/2/32/32  shared slave request.
REQ-011 s_addr_ok/s_data_ok/s_rdata  in  1/1/32  slave accept, in-order response, read data.
REQ-012 outstanding  out  $clog2(DEPTH)+1  count of accepted transactions awaiting s_data_ok.
REQ-013 err  out  1  sticky protocol error (s_data_ok with no transaction outstanding).

Function
REQ-014 Grant is combinational each cycle: data master wins when data_req=1, else instruction master when inst_req=1, else none.
REQ-015 s_req SHALL equal (granted master's req) AND NOT full; s_wr/s_size/s_addr/s_wdata SHALL mux from granted master (zero when no grant).
REQ-016 Granted master's addr_ok SHALL equal s_addr_ok AND s_req; the losing master's addr_ok SHALL be 0.
REQ-017 Accept = s_req AND s_addr_ok; on accept the granted master ID (0 inst, 1 data) is pushed into the owner FIFO at posedge.
REQ-018 On s_data_ok=1 with FIFO non-empty, the head ID is popped; that master's data_ok=1 and rdata=s_rdata in the same cycle, combinationally; the other master sees data_ok=0, rdata=0.
REQ-019 Responses SHALL be delivered strictly in acceptance order; zero added latency on either path.
REQ-020 Full (outstanding==DEPTH): s_req=0, both addr_ok=0, even if a pop occurs that cycle (no pop-then-push bypass).
REQ-021 Simultaneous push and pop when not full: count unchanged, both pointers advance.
REQ-022 s_data_ok=1 while empty: no pop, both data_ok=0, err set to 1 and held until reset.
REQ-023 Pointers wrap modulo DEPTH; outstanding SHALL never exceed DEPTH or go below 0.
REQ-024 Writes complete through s_data_ok exactly like reads; write responses pass s_rdata unmodified.

Reset
REQ-025 While rst=1 at posedge: FIFO pointers and outstanding cleared to 0, err cleared to 0.
REQ-026 While rst=1 all outputs SHALL be 0 (s_req, addr_ok, data_ok, rdata included), regardless of inputs.
REQ-027 Reset mid-operation drops all outstanding transactions; slave responses arriving later set err.

Structure
REQ-028 Shared package holds master-ID constants (MASTER_INST=0, MASTER_DATA=1) and size-encoding constants (byte, half, word).
REQ-029 Owner FIFO SHALL be one sub-module, arb_id_fifo (parameter DEPTH, 1-bit entries, push/pop/full/empty/count).
REQ-030 Target size 150-300 lines RTL total.

Verification
REQ-031 Bench: slave model with addr_ok=req, data_ok 3 cycles after acceptance, byte-masked writes, DEPTH=4.
REQ-032 Both masters request in the same cycle (data read 0x100, inst read 0x200) -> data accepted first, inst next cycle; data_data_ok at cycle 3, inst_data_ok at cycle 4, correct words returned.
REQ-033 Inst issues 4 back-to-back reads with slave latency 8 -> outstanding reaches 4, 5th request sees inst_addr_ok=0 until first response pops, then accepted the cycle after the pop.
REQ-034 Data byte write 0xAB to 0x103, then word read 0x100 -> read returns 0xAB in bits 31:24, other bytes unchanged.
REQ-035 Inject s_data_ok=1 with outstanding=0 -> both data_ok=0, err=1 and remains 1; rst clears it.
REQ-036 Assert rst with 3 outstanding -> next cycle outstanding=0, all outputs 0; subsequent requests granted normally.
